// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// Module   : memory_arbiter_pkg
// Brief    : State encodings, direction and frame-mask constants shared by the
//            arbiter and the memory interface.
// Revision : 1.0  initial release
// =============================================================================
package memory_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic c_READ  = 1'b0;
   localparam logic c_WRITE = 1'b1;

   localparam logic [3:0] c_MASK_B0 = 4'b0001;
   localparam logic [3:0] c_MASK_B1 = 4'b0010;
   localparam logic [3:0] c_MASK_B2 = 4'b0100;
   localparam logic [3:0] c_MASK_B3 = 4'b1000;
   localparam logic [3:0] c_MASK_H0 = 4'b0011;
   localparam logic [3:0] c_MASK_H1 = 4'b1100;
   localparam logic [3:0] c_MASK_W  = 4'b1111;

   // Only naturally aligned byte, halfword and word lanes reach the memory.
   function automatic logic mask_legal(input logic [3:0] mask);
      logic legal;
      case (mask)
         c_MASK_B0, c_MASK_B1, c_MASK_B2, c_MASK_B3,
         c_MASK_H0, c_MASK_H1, c_MASK_W: legal = 1'b1;
         default:                        legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_pick.sv
`default_nettype none
// =============================================================================
// Module   : memory_arbiter_pick
// Brief    : Data-priority grant selection with instruction anti-starvation.
// Revision : 1.0  initial release
// =============================================================================
module memory_arbiter_pick
   import memory_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic CLK,
   input  logic reset_n,
   input  logic arb_en,
   input  logic i_req,
   input  logic d_req,
   output logic grant_valid,
   output logic grant_data
);

   localparam int c_CW = $clog2(STARVE_LIMIT + 2);

   logic [c_CW-1:0] r_starve_cnt;
   logic            w_force_i;

   assign w_force_i   = i_req && (r_starve_cnt == c_CW'(STARVE_LIMIT));
   assign grant_valid = arb_en && (i_req || d_req);
   assign grant_data  = d_req && !w_force_i;

   // Counts data grants taken while a fetch was waiting.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_starve_cnt <= '0;
      end else if (arb_en) begin
         if (!i_req) begin
            r_starve_cnt <= '0;
         end else if (grant_valid && !grant_data) begin
            r_starve_cnt <= '0;
         end else if (grant_valid && (r_starve_cnt != c_CW'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + c_CW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : memory_arbiter
// Brief    : Arbitrates instruction-fetch and load/store requests onto one
//            memory command interface, with timeout and illegal-mask errors.
// Revision : 1.0  initial release
// =============================================================================
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int TIMEOUT      = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        reset_n,
   input  logic        i_req,
   input  logic [31:0] i_address,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [3:0]  d_frame_mask,
   input  logic [31:0] d_address,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_enable,
   output logic        mem_state,
   output logic [3:0]  mem_frame_mask,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_done
);

   localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t          r_state;
   state_t          w_next_state;
   logic            w_timeout;
   logic            w_grant_valid;
   logic            w_grant_data;
   logic            w_mask_ok;
   logic [c_TW-1:0] r_tcnt;
   logic            r_win_data;
   logic            r_err;
   logic            r_dir;
   logic [3:0]      r_mask;
   logic [31:0]     r_addr;
   logic [31:0]     r_wdata;
   logic [31:0]     r_i_rdata;
   logic [31:0]     r_d_rdata;

   memory_arbiter_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .CLK         (CLK),
      .reset_n     (reset_n),
      .arb_en      (r_state == ST_IDLE),
      .i_req       (i_req),
      .d_req       (d_req),
      .grant_valid (w_grant_valid),
      .grant_data  (w_grant_data)
   );

   assign w_mask_ok = mask_legal(d_frame_mask);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_valid) begin
               // A malformed data mask never reaches the memory.
               w_next_state = (w_grant_data && !w_mask_ok) ? ST_RESP : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (mem_done) begin
               w_next_state = ST_RESP;
            end else if (r_tcnt == c_TW'(TIMEOUT - 1)) begin
               w_next_state = ST_RESP;
               w_timeout    = 1'b1;
            end
         end
         ST_RESP: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_tcnt     <= '0;
         r_win_data <= 1'b0;
         r_err      <= 1'b0;
         r_dir      <= c_READ;
         r_mask     <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_i_rdata  <= '0;
         r_d_rdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_tcnt <= '0;
               if (w_grant_valid) begin
                  r_win_data <= w_grant_data;
                  r_err      <= w_grant_data && !w_mask_ok;
                  if (w_grant_data) begin
                     r_dir   <= d_write;
                     r_mask  <= d_frame_mask;
                     r_addr  <= d_address;
                     r_wdata <= (d_write == c_WRITE) ? d_wdata : 32'd0;
                  end else begin
                     r_dir   <= c_READ;
                     r_mask  <= c_MASK_W;
                     r_addr  <= i_address;
                     r_wdata <= 32'd0;
                  end
               end
            end
            ST_BUSY: begin
               if (mem_done) begin
                  if (r_win_data) begin
                     r_d_rdata <= mem_rdata;
                  end else begin
                     r_i_rdata <= mem_rdata;
                  end
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt + c_TW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign mem_enable     = (r_state == ST_BUSY);
   assign mem_state      = r_dir;
   assign mem_frame_mask = r_mask;
   assign mem_address    = r_addr;
   assign mem_wdata      = r_wdata;

   assign i_ack   = (r_state == ST_RESP) && !r_win_data;
   assign d_ack   = (r_state == ST_RESP) &&  r_win_data;
   assign i_err   = i_ack && r_err;
   assign d_err   = d_ack && r_err;
   assign i_rdata = r_i_rdata;
   assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_memory_arbiter
// Brief    : Self-checking bench for memory_arbiter with a response scoreboard
//            and a behavioural memory model.
// Revision : 1.0  initial release
// =============================================================================
module tb_memory_arbiter;
   import memory_arbiter_pkg::*;

   localparam int TIMEOUT      = 32;
   localparam int STARVE_LIMIT = 4;

   typedef struct {
      bit          is_d;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   typedef struct {
      logic        st;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          gap;
   } glog_t;

   logic        CLK = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_address = '0;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req = 1'b0;
   logic        d_write = 1'b0;
   logic [3:0]  d_frame_mask = '0;
   logic [31:0] d_address = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_enable;
   logic        mem_state;
   logic [3:0]  mem_frame_mask;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_done = 1'b0;

   int n_total = 0;
   int n_pass  = 0;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] last_i = '0;
   logic [31:0] last_d = '0;

   int          mem_latency = 2;
   bit          mem_never = 1'b0;
   bit          stray = 1'b0;
   logic [31:0] mem_data = '0;
   int          en_cnt = 0;
   int          low_cnt = 0;
   int          unstable = 0;
   glog_t       glog[$];
   glog_t       cur;

   always #5 CLK = ~CLK;

   memory_arbiter #(
      .TIMEOUT      (TIMEOUT),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .CLK            (CLK),
      .reset_n        (reset_n),
      .i_req          (i_req),
      .i_address      (i_address),
      .i_ack          (i_ack),
      .i_rdata        (i_rdata),
      .i_err          (i_err),
      .d_req          (d_req),
      .d_write        (d_write),
      .d_frame_mask   (d_frame_mask),
      .d_address      (d_address),
      .d_wdata        (d_wdata),
      .d_ack          (d_ack),
      .d_rdata        (d_rdata),
      .d_err          (d_err),
      .mem_enable     (mem_enable),
      .mem_state      (mem_state),
      .mem_frame_mask (mem_frame_mask),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_done       (mem_done)
   );

   // Memory model: logs each command, drives mem_done mem_latency cycles after enable.
   always @(posedge CLK) begin
      #1;
      mem_done  = 1'b0;
      mem_rdata = 32'hA5A5_0000 | 32'(en_cnt);
      if (mem_enable) begin
         if (en_cnt == 0) begin
            cur.st    = mem_state;
            cur.mask  = mem_frame_mask;
            cur.addr  = mem_address;
            cur.wdata = mem_wdata;
            cur.gap   = low_cnt;
            glog.push_back(cur);
         end else if (cur.st !== mem_state || cur.mask !== mem_frame_mask ||
                      cur.addr !== mem_address || cur.wdata !== mem_wdata) begin
            unstable++;
         end
         if (!mem_never && en_cnt == mem_latency) begin
            mem_done  = 1'b1;
            mem_rdata = mem_data;
         end
         en_cnt++;
         low_cnt = 0;
      end else begin
         en_cnt = 0;
         low_cnt++;
         if (stray) begin
            mem_done  = 1'b1;
            mem_rdata = 32'h0BAD_0BAD;
         end
      end
   end

   // Response monitor: every ack is matched against the scoreboard head.
   always @(negedge CLK) begin
      if (i_ack || d_ack) begin
         n_total++;
         if (i_ack && d_ack) $display("FAIL dual_ack: got i_ack=1 d_ack=1, want one");
         else n_pass++;
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b, want none", i_ack, d_ack);
         end else begin
            n_pass++;
            mon_e = sb.pop_front();
            n_total++;
            if (d_ack !== mon_e.is_d) $display("FAIL ack_port: got d_ack=%0b, want %0b", d_ack, mon_e.is_d);
            else n_pass++;
            n_total++;
            if ((mon_e.is_d ? d_rdata : i_rdata) !== mon_e.rdata)
               $display("FAIL ack_rdata: got %h, want %h", (mon_e.is_d ? d_rdata : i_rdata), mon_e.rdata);
            else n_pass++;
            n_total++;
            if ((mon_e.is_d ? d_err : i_err) !== mon_e.err)
               $display("FAIL ack_err: got %0b, want %0b", (mon_e.is_d ? d_err : i_err), mon_e.err);
            else n_pass++;
         end
         n_total++;
         if (mem_enable !== 1'b0) $display("FAIL resp_enable: got %0b, want 0", mem_enable);
         else n_pass++;
      end
   end

   task automatic expect_resp(input bit is_d, input logic [31:0] data, input bit err);
      exp_t e;
      e.is_d = is_d;
      e.err  = err;
      if (is_d) begin
         if (!err) last_d = data;
         e.rdata = last_d;
      end else begin
         if (!err) last_i = data;
         e.rdata = last_i;
      end
      sb.push_back(e);
   endtask

   task automatic wait_ack(input bit is_d, input int budget, output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      while (!ok && cyc < budget) begin
         @(negedge CLK);
         cyc++;
         if (is_d ? d_ack : i_ack) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_total++;
      if ({mem_enable, mem_state, mem_frame_mask, mem_address, mem_wdata} !== '0)
         $display("FAIL reset_mem: got %h, want 0", {mem_enable, mem_state, mem_frame_mask, mem_address, mem_wdata});
      else n_pass++;
      n_total++;
      if ({i_ack, d_ack, i_err, d_err} !== 4'b0000)
         $display("FAIL reset_ack: got %b, want 0000", {i_ack, d_ack, i_err, d_err});
      else n_pass++;
      n_total++;
      if ({i_rdata, d_rdata} !== 64'd0) $display("FAIL reset_rdata: got %h, want 0", {i_rdata, d_rdata});
      else n_pass++;
      reset_n = 1'b1;
      repeat (3) @(negedge CLK);
      n_total++;
      if ({mem_enable, i_ack, d_ack} !== 3'b000)
         $display("FAIL idle_after_reset: got %b, want 000", {mem_enable, i_ack, d_ack});
      else n_pass++;
   endtask

   task automatic test_ifetch();
      bit ok;
      int cyc;
      mem_latency = 4;
      mem_data    = 32'hDEAD_BEEF;
      i_address   = 32'h10;
      expect_resp(1'b0, 32'hDEAD_BEEF, 1'b0);
      @(posedge CLK); #1;
      i_req = 1'b1;
      @(negedge CLK);
      n_total++;
      if (mem_enable !== 1'b0) $display("FAIL ifetch_early_enable: got %0b, want 0", mem_enable);
      else n_pass++;
      @(negedge CLK);
      n_total++;
      if ({mem_enable, mem_state, mem_frame_mask, mem_address, mem_wdata} !== {1'b1, c_READ, 4'b1111, 32'h10, 32'h0})
         $display("FAIL ifetch_cmd: got en=%0b st=%0b m=%b a=%h w=%h, want 1 0 1111 10 0",
                  mem_enable, mem_state, mem_frame_mask, mem_address, mem_wdata);
      else n_pass++;
      wait_ack(1'b0, 50, ok, cyc);
      i_req = 1'b0;
      n_total++;
      if (!ok || cyc != mem_latency + 1) $display("FAIL ifetch_latency: got ok=%0b cyc=%0d, want 1 %0d", ok, cyc, mem_latency + 1);
      else n_pass++;
      @(negedge CLK);
      n_total++;
      if (i_ack !== 1'b0) $display("FAIL ifetch_pulse: got %0b, want 0", i_ack);
      else n_pass++;
      repeat (2) @(negedge CLK);
      n_total++;
      if (i_rdata !== 32'hDEAD_BEEF) $display("FAIL ifetch_hold: got %h, want deadbeef", i_rdata);
      else n_pass++;
   endtask

   task automatic test_data_read();
      bit ok;
      int cyc;
      glog.delete();
      mem_latency  = 3;
      mem_data     = 32'hCAFE_F00D;
      d_write      = c_READ;
      d_frame_mask = 4'b0100;
      d_address    = 32'h500;
      d_wdata      = 32'hFFFF_FFFF;
      expect_resp(1'b1, 32'hCAFE_F00D, 1'b0);
      @(posedge CLK); #1;
      d_req = 1'b1;
      wait_ack(1'b1, 50, ok, cyc);
      d_req = 1'b0;
      n_total++;
      if (!ok || cyc != mem_latency + 3) $display("FAIL dread_latency: got ok=%0b cyc=%0d, want 1 %0d", ok, cyc, mem_latency + 3);
      else n_pass++;
      n_total++;
      if (glog.size() != 1) $display("FAIL dread_grants: got %0d, want 1", glog.size());
      else begin
         n_pass++;
         n_total++;
         if ({glog[0].st, glog[0].mask, glog[0].addr, glog[0].wdata} !== {c_READ, 4'b0100, 32'h500, 32'h0})
            $display("FAIL dread_cmd: got st=%0b m=%b a=%h w=%h, want 0 0100 500 0",
                     glog[0].st, glog[0].mask, glog[0].addr, glog[0].wdata);
         else n_pass++;
      end
      n_total++;
      if (i_rdata !== last_i) $display("FAIL dread_iside: got %h, want %h", i_rdata, last_i);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      bit ok_i, ok_d;
      int ci, cd;
      glog.delete();
      mem_latency  = 2;
      mem_data     = 32'h1111_2222;
      i_address    = 32'h40;
      d_write      = c_WRITE;
      d_frame_mask = 4'b0011;
      d_address    = 32'h20;
      d_wdata      = 32'h0000_ABCD;
      expect_resp(1'b1, 32'h1111_2222, 1'b0);
      expect_resp(1'b0, 32'h1111_2222, 1'b0);
      @(posedge CLK); #1;
      i_req = 1'b1;
      d_req = 1'b1;
      fork
         begin wait_ack(1'b1, 100, ok_d, cd); d_req = 1'b0; end
         begin wait_ack(1'b0, 100, ok_i, ci); i_req = 1'b0; end
      join
      n_total++;
      if (!(ok_d && ok_i && cd < ci)) $display("FAIL simul_order: got ok_d=%0b ok_i=%0b cd=%0d ci=%0d, want data first", ok_d, ok_i, cd, ci);
      else n_pass++;
      n_total++;
      if (glog.size() != 2) $display("FAIL simul_grants: got %0d, want 2", glog.size());
      else begin
         n_pass++;
         n_total++;
         if ({glog[0].st, glog[0].mask, glog[0].addr, glog[0].wdata} !== {c_WRITE, 4'b0011, 32'h20, 32'h0000_ABCD})
            $display("FAIL simul_dcmd: got st=%0b m=%b a=%h w=%h, want 1 0011 20 0000abcd",
                     glog[0].st, glog[0].mask, glog[0].addr, glog[0].wdata);
         else n_pass++;
         n_total++;
         if ({glog[1].st, glog[1].mask, glog[1].addr, glog[1].wdata} !== {c_READ, 4'b1111, 32'h40, 32'h0})
            $display("FAIL simul_icmd: got st=%0b m=%b a=%h w=%h, want 0 1111 40 0",
                     glog[1].st, glog[1].mask, glog[1].addr, glog[1].wdata);
         else n_pass++;
         n_total++;
         if (glog[1].gap < 1) $display("FAIL simul_gap: got %0d, want >=1", glog[1].gap);
         else n_pass++;
      end
   endtask

   task automatic test_starvation();
      logic [31:0] exp_a [6];
      int nd = 0;
      int k  = 0;
      glog.delete();
      mem_latency  = 1;
      mem_data     = 32'h5A5A_0001;
      d_write      = c_READ;
      d_frame_mask = 4'b1111;
      d_address    = 32'h100;
      i_address    = 32'h200;
      for (int j = 0; j < 6; j++) begin
         exp_a[j] = (j == 4) ? 32'h200 : 32'h100;
         expect_resp(j != 4, 32'h5A5A_0001, 1'b0);
      end
      @(posedge CLK); #1;
      i_req = 1'b1;
      d_req = 1'b1;
      while (nd < 5 && k < 300) begin
         @(negedge CLK);
         k++;
         if (i_ack) i_req = 1'b0;
         if (d_ack) begin
            nd++;
            if (nd == 5) d_req = 1'b0;
         end
      end
      d_req = 1'b0;
      n_total++;
      if (nd != 5 || i_req !== 1'b0) $display("FAIL starve_done: got nd=%0d i_req=%0b, want 5 0", nd, i_req);
      else n_pass++;
      n_total++;
      if (glog.size() != 6) $display("FAIL starve_grants: got %0d, want 6", glog.size());
      else n_pass++;
      for (int j = 0; j < 6; j++) begin
         if (j < glog.size()) begin
            n_total++;
            if (glog[j].addr !== exp_a[j]) $display("FAIL starve_seq%0d: got %h, want %h", j, glog[j].addr, exp_a[j]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_timeout();
      int  k  = 0;
      int  hi = 0;
      bit  got = 1'b0;
      mem_never = 1'b1;
      i_address = 32'h300;
      expect_resp(1'b0, 32'h0, 1'b1);
      @(posedge CLK); #1;
      i_req = 1'b1;
      while (!got && k < 100) begin
         @(negedge CLK);
         k++;
         if (i_ack) got = 1'b1;
         else if (mem_enable) hi++;
      end
      i_req     = 1'b0;
      mem_never = 1'b0;
      n_total++;
      if (!got) $display("FAIL timeout_ack: got none, want ack");
      else n_pass++;
      n_total++;
      if (hi != TIMEOUT) $display("FAIL timeout_busy: got %0d, want %0d", hi, TIMEOUT);
      else n_pass++;
      n_total++;
      if (k != TIMEOUT + 2) $display("FAIL timeout_latency: got %0d, want %0d", k, TIMEOUT + 2);
      else n_pass++;
   endtask

   task automatic test_illegal_mask();
      bit ok;
      int cyc;
      glog.delete();
      d_write      = c_READ;
      d_frame_mask = 4'b0101;
      d_address    = 32'h400;
      expect_resp(1'b1, 32'h0, 1'b1);
      @(posedge CLK); #1;
      d_req = 1'b1;
      wait_ack(1'b1, 20, ok, cyc);
      d_req = 1'b0;
      n_total++;
      if (!ok || cyc != 2) $display("FAIL illegal_latency: got ok=%0b cyc=%0d, want 1 2", ok, cyc);
      else n_pass++;
      repeat (2) @(negedge CLK);
      n_total++;
      if (glog.size() != 0) $display("FAIL illegal_enable: got %0d grants, want 0", glog.size());
      else n_pass++;
   endtask

   task automatic test_stray_done();
      int acks = 0;
      @(negedge CLK);
      stray = 1'b1;
      @(posedge CLK); #2;
      stray = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         if (i_ack || d_ack || mem_enable) acks++;
      end
      n_total++;
      if (acks != 0) $display("FAIL stray_done: got %0d active cycles, want 0", acks);
      else n_pass++;
      n_total++;
      if ({i_rdata, d_rdata} !== {last_i, last_d})
         $display("FAIL stray_rdata: got %h %h, want %h %h", i_rdata, d_rdata, last_i, last_d);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int cyc;
      int acks = 0;
      mem_never = 1'b1;
      i_address = 32'h600;
      @(posedge CLK); #1;
      i_req = 1'b1;
      repeat (4) @(negedge CLK);
      n_total++;
      if (mem_enable !== 1'b1) $display("FAIL rstmid_busy: got %0b, want 1", mem_enable);
      else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_total++;
      if ({mem_enable, mem_state, mem_frame_mask, mem_address, mem_wdata} !== '0)
         $display("FAIL rstmid_mem: got %h, want 0", {mem_enable, mem_state, mem_frame_mask, mem_address, mem_wdata});
      else n_pass++;
      n_total++;
      if ({i_ack, d_ack, i_err, d_err, i_rdata, d_rdata} !== '0)
         $display("FAIL rstmid_resp: got %h, want 0", {i_ack, d_ack, i_err, d_err, i_rdata, d_rdata});
      else n_pass++;
      last_i    = '0;
      last_d    = '0;
      i_req     = 1'b0;
      mem_never = 1'b0;
      repeat (2) @(negedge CLK);
      reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         if (i_ack || d_ack) acks++;
      end
      n_total++;
      if (acks != 0) $display("FAIL rstmid_noack: got %0d, want 0", acks);
      else n_pass++;
      mem_latency = 2;
      mem_data    = 32'h1234_5678;
      i_address   = 32'h700;
      expect_resp(1'b0, 32'h1234_5678, 1'b0);
      @(posedge CLK); #1;
      i_req = 1'b1;
      wait_ack(1'b0, 50, ok, cyc);
      i_req = 1'b0;
      n_total++;
      if (!ok || cyc != mem_latency + 3) $display("FAIL rstmid_fresh: got ok=%0b cyc=%0d, want 1 %0d", ok, cyc, mem_latency + 3);
      else n_pass++;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_final();
      n_total++;
      if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
      else n_pass++;
      n_total++;
      if (unstable != 0) $display("FAIL mem_stable: got %0d changes, want 0", unstable);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_ifetch();
      test_data_read();
      test_simultaneous();
      test_starvation();
      test_timeout();
      test_illegal_mask();
      test_stray_done();
      test_reset_mid();
      test_final();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
